// File: rtl/gpr_writeback.sv
// -----------------------------------------------------------------------------
// gpr_writeback
//   Writeback stage in front of the general purpose register file. Results
//   from the ALU and the memory-load port are buffered in separate FIFOs and
//   drained into the register file's one-hot write-enable and per-register
//   data buses. A pending scoreboard tracks registers with writes in flight.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   alu_valid/alu_ready          ALU result handshake
//   alu_rd, alu_data             ALU destination register and value
//   mem_valid/mem_ready          load result handshake
//   mem_rd, mem_data             load destination register and value
//   issue_valid, issue_rd        marks issue_rd pending
//   wb_stall                     blocks all FIFO pops this cycle
//   we[15:0]                     registered one-cycle write enables
//   wdata[15:0][31:0]            registered write data per register
//   pending[15:0]                registered outstanding-write scoreboard
//   collision                    sticky: both FIFO heads targeted one register
// -----------------------------------------------------------------------------

// Single-producer FIFO holding {rd, data} entries.
module gpr_wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [3:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_valid,
  output logic [3:0]  head_rd,
  output logic [31:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [35:0]   store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;

  // Ready comes from registered count only, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign push_ready = (count < CW'(DEPTH));
  assign head_valid = (count != '0);
  assign push       = push_valid && push_ready;
  assign {head_rd, head_data} = store[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, and a
  // reset-free array maps onto plain RAM/flops without a clear network.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= {push_rd, push_data};
  end
endmodule

module gpr_writeback #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [3:0]        alu_rd,
  input  logic [31:0]       alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [3:0]        mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              issue_valid,
  input  logic [3:0]        issue_rd,
  input  logic              wb_stall,
  output logic [15:0]       we,
  output logic [15:0][31:0] wdata,
  output logic [15:0]       pending,
  output logic              collision
);
  logic        alu_head_valid, mem_head_valid;
  logic [3:0]  alu_head_rd, mem_head_rd;
  logic [31:0] alu_head_data, mem_head_data;
  logic        alu_pop, mem_pop, same_rd;
  logic [15:0] we_next, pending_next;

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (alu_valid),
    .push_ready (alu_ready),
    .push_rd    (alu_rd),
    .push_data  (alu_data),
    .pop        (alu_pop),
    .head_valid (alu_head_valid),
    .head_rd    (alu_head_rd),
    .head_data  (alu_head_data)
  );

  gpr_wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (mem_valid),
    .push_ready (mem_ready),
    .push_rd    (mem_rd),
    .push_data  (mem_data),
    .pop        (mem_pop),
    .head_valid (mem_head_valid),
    .head_rd    (mem_head_rd),
    .head_data  (mem_head_data)
  );

  // Same-register heads: the load retires first, the ALU head waits.
  assign same_rd = alu_head_valid && mem_head_valid && (alu_head_rd == mem_head_rd);
  assign mem_pop = !wb_stall && mem_head_valid;
  assign alu_pop = !wb_stall && alu_head_valid && !same_rd;

  // NOTE: combinational logic uses blocking assignments with every output
  // given a default first, so no path leaves a latch behind.
  always_comb begin
    we_next = '0;
    if (mem_pop) we_next[mem_head_rd] = 1'b1;
    if (alu_pop) we_next[alu_head_rd] = 1'b1;
    // Set after clear: a re-issue on the retiring edge keeps the bit high.
    pending_next = pending & ~we_next;
    if (issue_valid) pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we        <= '0;
      wdata     <= '0;
      pending   <= '0;
      collision <= 1'b0;
    end else begin
      we      <= we_next;
      pending <= pending_next;
      // Both pops never share an rd, so the two writes cannot conflict.
      if (mem_pop) wdata[mem_head_rd] <= mem_head_data;
      if (alu_pop) wdata[alu_head_rd] <= alu_head_data;
      if (same_rd) collision <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gpr_writeback.sv
// -----------------------------------------------------------------------------
// tb_gpr_writeback
//   Self-checking bench for gpr_writeback (DEPTH = 4). Every expected register
//   write is queued when stimulus is driven; a negedge monitor pops the queue
//   for each we bit it sees and compares register index and data.
// -----------------------------------------------------------------------------
module tb_gpr_writeback;
  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_valid = 1'b0, mem_valid = 1'b0;
  logic              alu_ready, mem_ready;
  logic [3:0]        alu_rd = '0, mem_rd = '0, issue_rd = '0;
  logic [31:0]       alu_data = '0, mem_data = '0;
  logic              issue_valid = 1'b0, wb_stall = 1'b0;
  logic [15:0]       we, pending;
  logic [15:0][31:0] wdata;
  logic              collision;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  gpr_writeback #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .wb_stall    (wb_stall),
    .we          (we),
    .wdata       (wdata),
    .pending     (pending),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Monitor: each write-enable bit retires the oldest queued result.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        if (we[i]) begin
          if (sb.size() == 0) begin
            check("we_unexpected", 32'(i), 32'hFFFF_FFFF);
          end else begin
            wb_t e;
            e = sb.pop_front();
            check("wb_rd", 32'(i), 32'(e.rd));
            check("wb_data", wdata[i], e.data);
          end
        end
      end
    end
  end

  // Called at posedge+1; the push lands on the next accepting edge.
  task automatic push_alu(input logic [3:0] rd, input logic [31:0] data);
    alu_valid = 1'b1; alu_rd = rd; alu_data = data;
    sb.push_back('{rd, data});
    for (int t = 0; t < 20 && !alu_ready; t++) begin
      @(posedge clk); #1;
    end
    if (!alu_ready) check("alu_ready_timeout", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0;
  endtask

  // Queue order models retirement: same-cycle writes are scanned in
  // ascending rd order, and on a shared rd the load retires first.
  task automatic push_both(input logic [3:0] ard, input logic [31:0] adata,
                           input logic [3:0] mrd, input logic [31:0] mdata);
    alu_valid = 1'b1; alu_rd = ard; alu_data = adata;
    mem_valid = 1'b1; mem_rd = mrd; mem_data = mdata;
    if (ard < mrd) begin
      sb.push_back('{ard, adata}); sb.push_back('{mrd, mdata});
    end else begin
      sb.push_back('{mrd, mdata}); sb.push_back('{ard, adata});
    end
    for (int t = 0; t < 20 && !(alu_ready && mem_ready); t++) begin
      @(posedge clk); #1;
    end
    if (!(alu_ready && mem_ready)) check("both_ready_timeout", 32'(alu_ready && mem_ready), 32'd1);
    @(posedge clk); #1;
    alu_valid = 1'b0; mem_valid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  // Asserts reset between edges and checks that it takes effect at once.
  task automatic check_reset_values(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | wdata[i];
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_wdata"}, acc, 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_collision"}, 32'(collision), 32'd0);
    check({tag, "_alu_ready"}, 32'(alu_ready), 32'd1);
    check({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    sb.delete();
    wb_stall = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] we_acc;

    // Power-on reset values.
    #3;
    check_reset_values("por");
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single ALU result: one we pulse starting one edge after the push.
    push_alu(4'd3, 32'hDEADBEEF);
    @(negedge clk); check("t1_we_before", 32'(we), 32'h0);
    @(negedge clk); check("t1_we_pulse", 32'(we), 32'h0008);
    check("t1_wdata3", wdata[3], 32'hDEADBEEF);
    @(negedge clk); check("t1_we_after", 32'(we), 32'h0);

    // Two producers, different registers: retire together.
    @(posedge clk); #1;
    push_both(4'd1, 32'h11, 4'd2, 32'h22);
    @(negedge clk); check("t2_we_before", 32'(we), 32'h0);
    @(negedge clk); check("t2_we_pair", 32'(we), 32'h0006);
    check("t2_wdata1", wdata[1], 32'h11);
    check("t2_wdata2", wdata[2], 32'h22);
    check("t2_collision", 32'(collision), 32'd0);
    @(negedge clk); check("t2_we_after", 32'(we), 32'h0);

    // Same register from both producers: load first, then ALU; sticky flag.
    @(posedge clk); #1;
    push_both(4'd5, 32'hA, 4'd5, 32'hB);
    @(negedge clk); check("t3_we_before", 32'(we), 32'h0);
    @(negedge clk); check("t3_we_mem", 32'(we), 32'h0020);
    check("t3_wdata5_mem", wdata[5], 32'hB);
    check("t3_collision_set", 32'(collision), 32'd1);
    @(negedge clk); check("t3_we_alu", 32'(we), 32'h0020);
    check("t3_wdata5_alu", wdata[5], 32'hA);
    repeat (4) @(negedge clk);
    check("t3_we_idle", 32'(we), 32'h0);
    check("t3_collision_sticky", 32'(collision), 32'd1);
    apply_reset("rst1");

    // Stall: four pushes fill the ALU FIFO, the fifth is held off.
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_alu(4'(8 + i), 32'h100 + 32'(i));
    @(negedge clk); check("t4_ready_full", 32'(alu_ready), 32'd0);
    alu_valid = 1'b1; alu_rd = 4'd12; alu_data = 32'h104;
    sb.push_back('{4'd12, 32'h104});
    repeat (2) begin
      @(negedge clk);
      check("t4_stall_we", 32'(we), 32'h0);
      check("t4_stall_ready", 32'(alu_ready), 32'd0);
    end
    @(posedge clk); #1;
    wb_stall = 1'b0;
    @(negedge clk); check("t4_we_release", 32'(we), 32'h0);
    @(posedge clk); #1;
    check("t4_ready_back", 32'(alu_ready), 32'd1);
    @(negedge clk); check("t4_pulse0", 32'(we), 32'h0100);
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk); check("t4_pulse1", 32'(we), 32'h0200);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); check("t4_pulse", 32'(we), 32'h1 << (8 + k));
    end
    @(negedge clk); check("t4_we_done", 32'(we), 32'h0);

    // Scoreboard: issue sets pending, the retiring edge clears it.
    @(posedge clk); #1;
    issue(4'd7);
    @(negedge clk); check("t5_pending_set", 32'(pending), 32'h0080);
    @(posedge clk); #1;
    push_alu(4'd7, 32'h77);
    @(negedge clk); check("t5_pending_held", 32'(pending), 32'h0080);
    @(negedge clk); check("t5_we7", 32'(we), 32'h0080);
    check("t5_pending_clr", 32'(pending), 32'h0);
    // Re-issue on the clearing edge: set wins.
    @(posedge clk); #1;
    issue(4'd7);
    push_alu(4'd7, 32'h78);
    issue_valid = 1'b1; issue_rd = 4'd7;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    @(negedge clk); check("t5_we7_again", 32'(we), 32'h0080);
    check("t5_set_wins", 32'(pending), 32'h0080);

    // Reset mid-operation with two entries buffered in each FIFO.
    @(posedge clk); #1;
    issue(4'd9);
    wb_stall = 1'b1;
    push_both(4'd1, 32'h1, 4'd3, 32'h3);
    push_both(4'd2, 32'h2, 4'd4, 32'h4);
    @(negedge clk);
    check("t6_pending_pre", 32'(pending), 32'h0280);
    check("t6_alu_ready_pre", 32'(alu_ready), 32'd1);
    apply_reset("rst2");
    we_acc = '0;
    repeat (10) begin
      @(negedge clk);
      we_acc = we_acc | we;
    end
    check("t6_no_we_after_rst", 32'(we_acc), 32'h0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/gpr_writeback.md
# gpr_writeback

Writeback stage placed directly upstream of `general_purpose_registers`. It accepts results from two producers, the ALU port and the memory-load port, through valid/ready handshakes and buffers each in its own FIFO. It drains the FIFOs into the register file's per-register `we[15:0]` and `inp[15:0]` buses. It also keeps a 16-bit pending scoreboard that issue logic uses to hold off on registers with writes still in flight.

## Interface
- `DEPTH`, default 4: entries per producer FIFO. Must be a power of two, 2..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `alu_valid`  in  1: ALU result offered.
- `alu_ready`  out  1: ALU FIFO can accept.
- `alu_rd`  in  4: destination register index.
- `alu_data`  in  32: result value.
- `mem_valid`  in  1: load result offered.
- `mem_ready`  out  1: memory FIFO can accept.
- `mem_rd`  in  4: destination register index.
- `mem_data`  in  32: load value.
- `issue_valid`  in  1: an instruction writing `issue_rd` was issued this cycle.
- `issue_rd`  in  4: register to mark pending.
- `wb_stall`  in  1: when high, no FIFO pops this cycle.
- `we`  out  16: registered write-enable, one bit per register; connects to the GPR `we`.
- `wdata`  out  32 x [15:0]: registered write data; connects to the GPR `inp`.
- `pending`  out  16: registered scoreboard, bit i = a write to register i is outstanding.
- `collision`  out  1: sticky error flag; set when both FIFO heads target the same register.

## Operation
- Each producer has its own FIFO of `DEPTH` entries, each entry {rd[3:0], data[31:0]}. The FIFO has read/write pointers and a count with DEPTH+1 states.
- `x_ready` = (count < DEPTH). It is derived only from registered count and does not depend on a same-cycle pop.
- A push happens on an edge where `x_valid && x_ready`.
- Pop rule, evaluated each cycle on the FIFO heads:
  - When `wb_stall` = 1, nothing pops.
  - Otherwise every non-empty FIFO pops its head.
  - Exception: if both heads are valid and `alu_rd == mem_rd`, only the memory head pops. The ALU head waits at least one cycle, and `collision` sets to 1 and stays set until reset.
- Output register update on every edge:
  - `we` is cleared to all zeros, then bit rd is set for each popped head.
  - `wdata[rd]` is loaded with the popped data.
  - `wdata` entries that are not written hold their previous value.
  - `we` is therefore high for exactly one cycle per retired result. Two results to different registers can retire in the same cycle.
- Scoreboard update on every edge:
  - Bit rd of each popped head clears.
  - Bit `issue_rd` sets when `issue_valid` = 1.
  - If the same register is both set and cleared on one edge, the set wins.
- Issue logic guarantees at most one outstanding write per register. It does this by not issuing when `pending[rd]` = 1. `collision` therefore indicates a protocol violation.
- Simultaneous push and pop on the same FIFO in one cycle: count is unchanged, and a full FIFO does not accept the push because `ready` was low.
- Pointers wrap modulo `DEPTH`.

## Timing
- Reset: the following values apply immediately on `rst` rise and hold while it is high.
  - FIFOs are empty, so `alu_ready` = `mem_ready` = 1.
  - `we` = 0, all `wdata` = 0, `pending` = 0, `collision` = 0.
- Reset in mid-operation discards all buffered results; nothing they carried is written.
- Latency, with the result pushed at edge A into an empty FIFO and no stall:
  - The head pops at edge A+1.
  - `we[rd]` is high from edge A+1 to edge A+2.
  - The GPR captures the value at edge A+2.
- Throughput: one result per producer per cycle when there is no collision and no stall.
- `pending[rd]` clears at the same edge that raises `we[rd]`.
- A stall of N cycles delays every pop by exactly N cycles. A FIFO that fills during the stall drops `ready` and keeps it low until a pop has registered.

## Test plan
- Reset, then push ALU {rd=3, data=0xDEADBEEF}: `we` = 0x0008 for exactly one cycle, starting one edge after the push, with `wdata[3]` = 0xDEADBEEF. `we` is 0 at all other times.
- In the same cycle push ALU {rd=1, 0x11} and MEM {rd=2, 0x22}: `we` = 0x0006 for one cycle with both data values correct; `collision` stays 0.
- Push ALU {rd=5, 0xA} and MEM {rd=5, 0xB} in the same cycle:
  - First the cycle with `we` = 0x0020 and `wdata[5]` = 0xB.
  - Next the cycle with `we` = 0x0020 and `wdata[5]` = 0xA.
  - `collision` = 1 from then until reset.
- Hold `wb_stall` = 1 and push 5 ALU results with DEPTH = 4:
  - `alu_ready` falls after the 4th push; the 5th is held off.
  - After stall release, 4 consecutive single-bit `we` pulses appear in push order, then the 5th result.
- Drive `issue_valid` with rd = 7 and then push ALU rd = 7:
  - `pending[7]` = 1 from the issue edge until the edge that asserts `we[7]`.
  - `issue_valid` rd = 7 on that same clearing edge leaves `pending[7]` = 1.
- Assert `rst` asynchronously while both FIFOs hold 2 entries each: all outputs reach their reset values before the next clock edge, and no `we` pulse follows deassertion.
